// File: rtl/axi3_mem_slave_if.sv
// AXI3 slave-port bundle (AR/R/AW/W/B) between an IP master port and axi3_mem_slave.
interface axi3_mem_slave_if;
  logic [31:0] SAXI_ARADDR;
  logic        SAXI_ARVALID;
  logic        SAXI_ARREADY;
  logic [3:0]  SAXI_ARLEN;
  logic [1:0]  SAXI_ARSIZE;
  logic [1:0]  SAXI_ARBURST;

  logic [63:0] SAXI_RDATA;
  logic        SAXI_RVALID;
  logic        SAXI_RREADY;
  logic [1:0]  SAXI_RRESP;
  logic        SAXI_RLAST;

  logic [31:0] SAXI_AWADDR;
  logic        SAXI_AWVALID;
  logic        SAXI_AWREADY;
  logic [3:0]  SAXI_AWLEN;
  logic [1:0]  SAXI_AWSIZE;
  logic [1:0]  SAXI_AWBURST;

  logic [63:0] SAXI_WDATA;
  logic [7:0]  SAXI_WSTRB;
  logic        SAXI_WVALID;
  logic        SAXI_WREADY;
  logic        SAXI_WLAST;

  logic [1:0]  SAXI_BRESP;
  logic        SAXI_BVALID;
  logic        SAXI_BREADY;

  modport slave (
    input  SAXI_ARADDR, SAXI_ARVALID, SAXI_ARLEN, SAXI_ARSIZE, SAXI_ARBURST,
    output SAXI_ARREADY,
    output SAXI_RDATA, SAXI_RVALID, SAXI_RRESP, SAXI_RLAST,
    input  SAXI_RREADY,
    input  SAXI_AWADDR, SAXI_AWVALID, SAXI_AWLEN, SAXI_AWSIZE, SAXI_AWBURST,
    output SAXI_AWREADY,
    input  SAXI_WDATA, SAXI_WSTRB, SAXI_WVALID, SAXI_WLAST,
    output SAXI_WREADY,
    output SAXI_BRESP, SAXI_BVALID,
    input  SAXI_BREADY
  );

  modport master (
    output SAXI_ARADDR, SAXI_ARVALID, SAXI_ARLEN, SAXI_ARSIZE, SAXI_ARBURST,
    input  SAXI_ARREADY,
    input  SAXI_RDATA, SAXI_RVALID, SAXI_RRESP, SAXI_RLAST,
    output SAXI_RREADY,
    output SAXI_AWADDR, SAXI_AWVALID, SAXI_AWLEN, SAXI_AWSIZE, SAXI_AWBURST,
    input  SAXI_AWREADY,
    output SAXI_WDATA, SAXI_WSTRB, SAXI_WVALID, SAXI_WLAST,
    input  SAXI_WREADY,
    input  SAXI_BRESP, SAXI_BVALID,
    output SAXI_BREADY
  );
endinterface

// File: rtl/axi3_mem_slave.sv
// Simulation AXI3 memory responder: 64-bit INCR bursts, fixed read latency, AR queue.
// Optional protocol/range checking with error responses is enabled by MEMSIM_ERRCHECK_EN.
module axi3_mem_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int unsigned MEM_WORDS  = 65536,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned AR_DEPTH   = 4
) (
  input  logic                   IP_CLK,
  input  logic                   IP_ARESET_N,
  axi3_mem_slave_if.slave        saxi,
  output logic [15:0]            ERR_COUNT
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = $clog2(AR_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_e;

  function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 3);
  endfunction

  logic [63:0] mem_q [MEM_WORDS];

  // AR queue storage and pointers
  logic [IDX_W-1:0] fifo_idx_q [AR_DEPTH];
  logic [3:0]       fifo_len_q [AR_DEPTH];
  logic             fifo_err_q [AR_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             arready_q, arready_d;
  logic             ar_push, ar_pop, fifo_empty;
  logic             ar_err, aw_err, w_last_mis;

  r_state_e         r_state_q, r_state_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [3:0]       r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic             r_err_q, r_err_d, r_err_evt;
  logic [7:0]       r_cnt_q, r_cnt_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]       rresp_q, rresp_d;

  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [3:0]       w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic             w_err_q, w_err_d, w_lerr_q, w_lerr_d, w_err_evt;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_hs, w_hs, mem_we;
  logic [63:0]      wmask;

  logic [15:0]      err_count_q, err_count_d;
  logic [16:0]      err_sum;

`ifdef MEMSIM_ERRCHECK_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd8;
  logic [32:0] ar_off, aw_off;
  // Below-base addresses underflow into bit 32 and so also fail the bound check
  assign ar_off     = 33'(saxi.SAXI_ARADDR) - 33'(ADDR_BASE);
  assign aw_off     = 33'(saxi.SAXI_AWADDR) - 33'(ADDR_BASE);
  assign ar_err     = (saxi.SAXI_ARSIZE != 2'd3) | (saxi.SAXI_ARBURST != 2'b01) | (ar_off >= MEM_BYTES);
  assign aw_err     = (saxi.SAXI_AWSIZE != 2'd3) | (saxi.SAXI_AWBURST != 2'b01) | (aw_off >= MEM_BYTES);
  assign w_last_mis = saxi.SAXI_WLAST != (w_beat_q == w_len_q);
`else
  logic unused_chk;
  assign unused_chk = ^{saxi.SAXI_ARSIZE, saxi.SAXI_ARBURST, saxi.SAXI_AWSIZE,
                        saxi.SAXI_AWBURST, saxi.SAXI_WLAST};
  assign ar_err     = 1'b0;
  assign aw_err     = 1'b0;
  assign w_last_mis = 1'b0;
`endif

  assign ar_push    = saxi.SAXI_ARVALID & arready_q;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    wr_ptr_d  = ar_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = ar_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(ar_push) - CNT_W'(ar_pop);
    arready_d = (count_d != CNT_W'(AR_DEPTH));
  end

  always_ff @(posedge IP_CLK) begin
    if (ar_push) begin
      fifo_idx_q[wr_ptr_q] <= to_idx(saxi.SAXI_ARADDR);
      fifo_len_q[wr_ptr_q] <= saxi.SAXI_ARLEN;
      fifo_err_q[wr_ptr_q] <= ar_err;
    end
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      arready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      arready_q <= arready_d;
    end
  end

  // Read engine: state register
  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) r_state_q <= R_IDLE;
    else              r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (!fifo_empty) r_state_d = R_WAIT;
      R_WAIT:  if (r_cnt_q == 8'd1) r_state_d = R_BURST;
      R_BURST: if (rvalid_q & saxi.SAXI_RREADY & rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ar_pop    = 1'b0;
    r_err_evt = 1'b0;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_err_d   = r_err_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (!fifo_empty) begin
          ar_pop   = 1'b1;
          r_idx_d  = fifo_idx_q[rd_ptr_q];
          r_len_d  = fifo_len_q[rd_ptr_q];
          r_err_d  = fifo_err_q[rd_ptr_q];
          r_cnt_d  = 8'(RD_LATENCY);
          r_beat_d = 4'd0;
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 8'd1;
        if (r_cnt_q == 8'd1) begin
          rvalid_d  = 1'b1;
          rdata_d   = r_err_q ? 64'd0 : mem_q[r_idx_q];
          rlast_d   = (r_len_q == 4'd0);
          rresp_d   = r_err_q ? 2'b10 : 2'b00;
          r_err_evt = r_err_q;
        end
      end
      R_BURST: begin
        if (rvalid_q & saxi.SAXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rresp_d  = 2'b00;
          end else begin
            // Fetch the next word on the accepting edge for back-to-back beats
            r_beat_d = r_beat_q + 4'd1;
            r_idx_d  = r_idx_q + IDX_W'(1);
            rdata_d  = r_err_q ? 64'd0 : mem_q[r_idx_q + IDX_W'(1)];
            rlast_d  = ((r_beat_q + 4'd1) == r_len_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      r_idx_q  <= '0;
      r_len_q  <= '0;
      r_beat_q <= '0;
      r_err_q  <= 1'b0;
      r_cnt_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= 2'b00;
    end else begin
      r_idx_q  <= r_idx_d;
      r_len_q  <= r_len_d;
      r_beat_q <= r_beat_d;
      r_err_q  <= r_err_d;
      r_cnt_q  <= r_cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
    end
  end

  assign aw_hs = saxi.SAXI_AWVALID & awready_q;
  assign w_hs  = saxi.SAXI_WVALID & wready_q;

  // Write engine: state register
  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) w_state_q <= W_ADDR;
    else              w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_ADDR:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && (w_beat_q == w_len_q)) w_state_d = W_RESP;
      W_RESP:  if (bvalid_q & saxi.SAXI_BREADY) w_state_d = W_ADDR;
      default: w_state_d = W_ADDR;
    endcase
  end

  always_comb begin
    awready_d = (w_state_d == W_ADDR);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    w_lerr_d  = w_lerr_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_err_evt = 1'b0;
    case (w_state_q)
      W_ADDR: begin
        if (aw_hs) begin
          w_idx_d  = to_idx(saxi.SAXI_AWADDR);
          w_len_d  = saxi.SAXI_AWLEN;
          w_err_d  = aw_err;
          w_lerr_d = 1'b0;
          w_beat_d = 4'd0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          mem_we   = !w_err_q;
          w_idx_d  = w_idx_q + IDX_W'(1);
          w_beat_d = w_beat_q + 4'd1;
          w_lerr_d = w_lerr_q | w_last_mis;
          if (w_beat_q == w_len_q) begin
            bresp_d   = (w_err_q | w_lerr_d) ? 2'b10 : 2'b00;
            w_err_evt = w_err_q | w_lerr_d;
          end
        end
      end
      W_RESP: if (bvalid_q & saxi.SAXI_BREADY) bresp_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      w_lerr_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      w_lerr_q  <= w_lerr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    for (int b = 0; b < 8; b++) wmask[b*8 +: 8] = {8{saxi.SAXI_WSTRB[b]}};
  end

  // Array is never reset; the read path samples it combinationally so a same-edge write is not seen
  always_ff @(posedge IP_CLK) begin
    if (mem_we) mem_q[w_idx_q] <= (mem_q[w_idx_q] & ~wmask) | (saxi.SAXI_WDATA & wmask);
  end

  always_comb begin
    err_sum     = 17'(err_count_q) + 17'(r_err_evt) + 17'(w_err_evt);
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) err_count_q <= '0;
    else              err_count_q <= err_count_d;
  end

  assign saxi.SAXI_ARREADY = arready_q;
  assign saxi.SAXI_RDATA   = rdata_q;
  assign saxi.SAXI_RVALID  = rvalid_q;
  assign saxi.SAXI_RRESP   = rresp_q;
  assign saxi.SAXI_RLAST   = rlast_q;
  assign saxi.SAXI_AWREADY = awready_q;
  assign saxi.SAXI_WREADY  = wready_q;
  assign saxi.SAXI_BVALID  = bvalid_q;
  assign saxi.SAXI_BRESP   = bresp_q;
  assign ERR_COUNT         = err_count_q;

endmodule
